// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared state encoding and constants for the instruction fetch
//               controller. Macro FETCH_MISALIGN_CHECK_EN adds the ERR state.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INST_BYTES = 4;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        FLUSH = 3'd3,
        ERR   = 3'd4
    } fetch_state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        FLUSH = 3'd3
    } fetch_state_e;
`endif

endpackage
`default_nettype wire

// File: rtl/pc_incr.sv
`default_nettype none
// ============================================================================
// Module      : pc_incr
// Description : Combinational next-PC unit: sequential increment or redirect
//               target. Macro FETCH_MISALIGN_CHECK_EN keeps raw target bits
//               and reports misalignment; otherwise bits [1:0] are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_incr
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  take_target,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic                  target_misaligned,
`endif
    output logic [ADDR_WIDTH-1:0] pc_next
);

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] target_eff;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target_misaligned = |target[1:0];
    assign target_eff        = target;
`else
    assign target_eff        = target & ALIGN_MASK;
`endif

    // Increment wraps naturally at 2^ADDR_WIDTH.
    assign pc_next = take_target ? target_eff : (pc + STEP);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Wishbone instruction fetch controller with redirect/flush
//               handling. Macro FETCH_MISALIGN_CHECK_EN enables the ERR state.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_we_o,
    input  logic                    wb_ack_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    inst_valid_o,
    output logic [DATA_WIDTH-1:0]   inst_o,
    output logic [ADDR_WIDTH-1:0]   inst_pc_o,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic                    exc_misalign_o
);

    fetch_state_e          state;
    fetch_state_e          state_nxt;
    logic [ADDR_WIDTH-1:0] target_q;
    logic [ADDR_WIDTH-1:0] target_sel;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  pc_load;
    logic                  take_target;
    logic                  store_target;
    logic                  capture;
    logic                  bus_nxt;
    logic                  valid_nxt;
    logic                  exc_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  misaligned;
`endif

    pc_incr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_incr (
        .pc                (pc_o),
        .target            (target_sel),
        .take_target       (take_target),
`ifdef FETCH_MISALIGN_CHECK_EN
        .target_misaligned (misaligned),
`endif
        .pc_next           (pc_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_load      = 1'b0;
        take_target  = 1'b0;
        store_target = 1'b0;
        capture      = 1'b0;
        target_sel   = redirect_pc_i;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect_i) begin
                    pc_load     = 1'b1;
                    take_target = 1'b1;
                end
            end
            FETCH: begin
                if (wb_ack_i) begin
                    pc_load = 1'b1;
                    if (redirect_i) begin
                        take_target = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (redirect_i) begin
                    store_target = 1'b1;
                    state_nxt    = FLUSH;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_load     = 1'b1;
                    take_target = 1'b1;
                    state_nxt   = IDLE;
                end else if (!stall_i) begin
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                store_target = redirect_i;
                // A redirect arriving with the ack is newer than the stored one.
                if (wb_ack_i) begin
                    pc_load     = 1'b1;
                    take_target = 1'b1;
                    target_sel  = redirect_i ? redirect_pc_i : target_q;
                    state_nxt   = IDLE;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            ERR: begin
                if (redirect_i) begin
                    pc_load     = 1'b1;
                    take_target = 1'b1;
                    state_nxt   = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        // Any misaligned target that gets applied parks the fetcher in ERR.
        if (take_target && misaligned) begin
            state_nxt = ERR;
        end
`endif
    end

    always_comb begin
        bus_nxt   = (state_nxt == FETCH) || (state_nxt == FLUSH);
        valid_nxt = (state_nxt == HOLD);
`ifdef FETCH_MISALIGN_CHECK_EN
        exc_nxt   = (state_nxt == ERR);
`else
        exc_nxt   = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_o           <= PC_ADDR;
            target_q       <= '0;
            inst_o         <= '0;
            inst_pc_o      <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            inst_valid_o   <= 1'b0;
            exc_misalign_o <= 1'b0;
        end else begin
            if (pc_load) begin
                pc_o <= pc_next;
            end
            if (store_target) begin
                target_q <= redirect_pc_i;
            end
            if (capture) begin
                inst_o    <= wb_dat_i;
                inst_pc_o <= pc_o;
            end
            wb_cyc_o       <= bus_nxt;
            wb_stb_o       <= bus_nxt;
            inst_valid_o   <= valid_nxt;
            exc_misalign_o <= exc_nxt;
        end
    end

    assign wb_adr_o = pc_o;
    assign wb_sel_o = '1;
    assign wb_we_o  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Scoreboard bench for pc_fetch_ctrl; expectations for the
//               FETCH_MISALIGN_CHECK_EN build follow the same macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam logic [31:0] K = 32'h5A5A_1234;

    typedef struct {
        logic [31:0] adr;
        bit          deliver;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;

    logic        cyc, stb, we, ack, valid, exc;
    logic [31:0] adr, dat, inst, inst_pc, pc;
    logic [3:0]  sel;

    logic        cyc2, stb2, we2, ack2, valid2, exc2;
    logic [31:0] adr2, dat2, inst2, inst_pc2, pc2;
    logic [3:0]  sel2;

    int          ack_delay = 1;
    int          cnt;
    int          n_checks = 0;
    int          n_pass = 0;

    bus_t        bus_q[$];
    logic [31:0] inst_q[$];
    logic [31:0] wrap_q[$];
    bus_t        mon_e;
    logic [31:0] mon_a;
    logic        valid_d;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .wb_cyc_o(cyc), .wb_stb_o(stb),
        .wb_adr_o(adr), .wb_sel_o(sel), .wb_we_o(we), .wb_ack_i(ack),
        .wb_dat_i(dat), .inst_valid_o(valid), .inst_o(inst),
        .inst_pc_o(inst_pc), .pc_o(pc), .exc_misalign_o(exc)
    );

    pc_fetch_ctrl #(.PC_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .wb_cyc_o(cyc2), .wb_stb_o(stb2),
        .wb_adr_o(adr2), .wb_sel_o(sel2), .wb_we_o(we2), .wb_ack_i(ack2),
        .wb_dat_i(dat2), .inst_valid_o(valid2), .inst_o(inst2),
        .inst_pc_o(inst_pc2), .pc_o(pc2), .exc_misalign_o(exc2)
    );

    assign dat  = adr ^ K;
    assign dat2 = adr2 ^ K;

    // Slave with programmable latency: ack arrives ack_delay cycles after request.
    always @(posedge clk) begin
        if (!rst_n) begin
            ack <= 1'b0;
            cnt <= 0;
        end else if (ack) begin
            ack <= 1'b0;
            cnt <= 0;
        end else if (cyc && stb) begin
            if (cnt + 1 >= ack_delay) ack <= 1'b1;
            else cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) ack2 <= 1'b0;
        else        ack2 <= !ack2 && cyc2 && stb2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc && stb && ack) begin
                if (bus_q.size() == 0) begin
                    check_eq("bus_unexpected", bus_q.size(), 1);
                end else begin
                    mon_e = bus_q.pop_front();
                    check_eq("bus_adr", adr, mon_e.adr);
                    if (mon_e.deliver) inst_q.push_back(mon_e.adr);
                end
            end
            if (valid && !valid_d) begin
                if (inst_q.size() == 0) begin
                    check_eq("inst_unexpected", inst_q.size(), 1);
                end else begin
                    mon_a = inst_q.pop_front();
                    check_eq("inst_pc", inst_pc, mon_a);
                    check_eq("inst_data", inst, mon_a ^ K);
                end
            end
            if (cyc2 && stb2 && ack2 && wrap_q.size() != 0) begin
                mon_a = wrap_q.pop_front();
                check_eq("wrap_adr", adr2, mon_a);
            end
        end
        valid_d <= valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input bit d);
        bus_t e;
        e.adr     = a;
        e.deliver = d;
        bus_q.push_back(e);
    endtask

    task automatic pulse(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        step();
        redirect    = 1'b0;
    endtask

    task automatic wait_hold(input logic [31:0] a, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (valid && inst_pc == a) begin
                found = 1'b1;
                break;
            end
        end
        check_eq(tag, found, 1);
    endtask

    task automatic release_hold();
        stall = 1'b0;
        step();
        stall = 1'b1;
    endtask

    initial begin
        int   rise[3];
        int   nr;
        logic pv;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        valid_d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pc", pc, 32'h8000_0000);
        check_eq("rst_cyc", {cyc, stb}, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_sel_we", {sel, we}, 5'b11110);
        check_eq("rst_exc", exc, 0);
        check_eq("rst_inst", inst, 0);
        check_eq("rst_pc_wrap", pc2, 32'hFFFF_FFFC);

        push(32'h8000_0000, 1); push(32'h8000_0004, 1);
        push(32'h8000_0008, 1); push(32'h8000_000C, 1);
        wrap_q.push_back(32'hFFFF_FFFC); wrap_q.push_back(32'h0000_0000);
        rst_n = 1'b1;

        // Free-running fetch; stall is raised inside the third HOLD cycle.
        nr = 0; pv = 1'b0;
        for (int c = 0; c < 60 && nr < 3; c++) begin
            step();
            if (valid && !pv) begin
                rise[nr] = c;
                nr++;
            end
            pv = valid;
        end
        stall = 1'b1;
        check_eq("rise_count", nr, 3);
        check_eq("period_1", rise[1] - rise[0], 3);
        check_eq("period_2", rise[2] - rise[1], 3);

        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_inst_pc", inst_pc, 32'h8000_0008);
            check_eq("stall_inst", inst, 32'h8000_0008 ^ K);
            check_eq("stall_bus", {cyc, valid}, 2'b01);
        end
        release_hold();
        check_eq("resume_cyc", cyc, 1);
        check_eq("resume_adr", adr, 32'h8000_000C);
        wait_hold(32'h8000_000C, "hold_c");

        // Redirect during an outstanding fetch with a slow slave.
        ack_delay = 3;
        push(32'h8000_0010, 0); push(32'h8000_0100, 1);
        release_hold();
        check_eq("fetch_adr_10", {31'h0, cyc} ^ adr, 32'h8000_0011);
        pulse(32'h8000_0100);
        check_eq("flush_cyc", {cyc, valid}, 2'b10);
        check_eq("flush_adr", adr, 32'h8000_0010);
        wait_hold(32'h8000_0100, "hold_100");

        // Two redirects while flushing: the later one wins.
        ack_delay = 4;
        push(32'h8000_0104, 0); push(32'h8000_0300, 1);
        release_hold();
        pulse(32'h8000_0200);
        pulse(32'h8000_0300);
        check_eq("flush2_adr", adr, 32'h8000_0104);
        wait_hold(32'h8000_0300, "hold_300");

        // Misaligned redirect from HOLD while stalled.
        ack_delay = 1;
`ifdef FETCH_MISALIGN_CHECK_EN
        pulse(32'h8000_0102);
        check_eq("err_valid", valid, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq("err_exc", exc, 1);
            check_eq("err_bus", cyc, 0);
            step();
        end
        check_eq("err_pc", pc, 32'h8000_0102);
        push(32'h8000_0104, 1);
        pulse(32'h8000_0104);
        check_eq("err_exit_exc", exc, 0);
        wait_hold(32'h8000_0104, "hold_104");
`else
        push(32'h8000_0100, 1);
        pulse(32'h8000_0102);
        check_eq("redir_valid_drop", valid, 0);
        check_eq("redir_pc_aligned", pc, 32'h8000_0100);
        wait_hold(32'h8000_0100, "hold_100_again");
        check_eq("no_exc", exc, 0);
`endif

        step();
        check_eq("bus_q_drained", bus_q.size(), 0);
        check_eq("inst_q_drained", inst_q.size(), 0);
        check_eq("wrap_q_drained", wrap_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_ADDR, default 32'h8000_0000, which is the fetch address after reset.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, which is the PC and bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, which is the instruction and bus data width.
REQ-004 SHALL have ports as follows:
- clk_i  in  1  clock (one clock).
- rst_ni  in  1  reset, asynchronous, active-low.
- stall_i  in  1  downstream cannot accept the held instruction.
- redirect_i  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc_i  in  ADDR_WIDTH  redirect target.
- wb_cyc_o, wb_stb_o  out  1  Wishbone bus request.
- wb_adr_o  out  ADDR_WIDTH  fetch address.
- wb_sel_o  out  DATA_WIDTH/8  byte lanes, always all-ones.
- wb_we_o  out  1  always 0.
- wb_ack_i  in  1  bus acknowledge.
- wb_dat_i  in  DATA_WIDTH  read data.
- inst_valid_o  out  1  inst_o/inst_pc_o are valid.
- inst_o  out  DATA_WIDTH  fetched instruction.
- inst_pc_o  out  ADDR_WIDTH  address of inst_o.
- pc_o  out  ADDR_WIDTH  current fetch PC.
- exc_misalign_o  out  1  misaligned-target exception (see REQ-021).

Function
REQ-005 SHALL implement the states IDLE, FETCH, HOLD, FLUSH, and ERR (ERR only when configured).
REQ-006 All outputs SHALL be registered; wb_cyc_o = wb_stb_o = 1 exactly in FETCH and FLUSH, with wb_adr_o = pc_o.
REQ-007 IDLE SHALL move to FETCH unconditionally on the next clock.
REQ-008 In FETCH, on wb_ack_i without redirect_i: inst_o <= wb_dat_i, inst_pc_o <= pc, pc <= pc+4, then go to HOLD.
REQ-009 In HOLD, inst_valid_o SHALL be 1 and the bus idle; leave for FETCH on the first cycle with stall_i = 0.
REQ-010 Throughput SHALL be one instruction per 3 cycles for a slave that acks one cycle after request with stall_i = 0.
REQ-011 stall_i SHALL have no effect in IDLE, FETCH, or FLUSH.
REQ-012 A redirect in FETCH without ack SHALL go to FLUSH, store the target, and keep cyc/stb asserted until ack.
REQ-013 In FLUSH, on ack the data SHALL be discarded, pc <= stored target, and the state SHALL go to IDLE.
REQ-014 A redirect in FETCH coinciding with ack SHALL discard the data, set pc <= redirect_pc_i, and go to IDLE.
REQ-015 A redirect in HOLD SHALL drop inst_valid_o next cycle, set pc <= redirect_pc_i, and go to IDLE, even when stall_i = 1.
REQ-016 A redirect in IDLE SHALL set pc <= redirect_pc_i.
REQ-017 A redirect in FLUSH SHALL overwrite the stored target (latest wins).
REQ-018 Increment SHALL be modulo 2^ADDR_WIDTH: pc 32'hFFFF_FFFC + 4 yields 32'h0000_0000.
REQ-019 inst_valid_o SHALL be 1 only in HOLD; inst_o and inst_pc_o SHALL be stable throughout HOLD.

Reset
REQ-020 rst_ni low SHALL immediately force: state IDLE, pc_o = PC_ADDR, all other outputs 0 (wb_sel_o all-ones), stored target 0. Any bus cycle in flight is abandoned; an ack after reset is ignored.

Configuration
REQ-021 Macro FETCH_MISALIGN_CHECK_EN SHALL control misaligned-target handling.
- Defined: a redirect target (direct or stored) with bits [1:0] != 0 is applied as pc, and the state goes to ERR instead of IDLE. In ERR, exc_misalign_o = 1 and no bus cycles occur. Only an aligned redirect leaves ERR, going to IDLE with pc = target.
- Undefined: target bits [1:0] are forced to 0, no ERR state exists, and exc_misalign_o is tied 0.

Structure
REQ-022 Package fetch_pkg SHALL hold the state enum fetch_state_e and the constant INST_BYTES = 4.
REQ-023 Sub-module pc_incr SHALL be a combinational unit: pc + INST_BYTES, or the selected redirect target.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Reset release, ack-after-1 slave, stall_i = 0: wb_adr_o sequence 8000_0000, 8000_0004, 8000_0008; inst_valid_o pulses every 3 cycles.
- stall_i = 1 for 5 cycles in HOLD: inst_o and inst_pc_o held, no cyc; fetch resumes the cycle after stall drops.
- Redirect to 8000_0100 in FETCH, ack delayed 3 cycles: data discarded, no inst_valid_o, next wb_adr_o = 8000_0100.
- Two redirects in FLUSH (8000_0200, then 8000_0300): next fetch at 8000_0300.
- PC_ADDR = 32'hFFFF_FFFC: second fetch address is 0000_0000.
- Macro defined, redirect to 8000_0102: exc_misalign_o = 1, no bus activity; a redirect to 8000_0104 resumes fetch. Macro undefined, same redirect: fetch at 8000_0100.
